// File: rtl/fp_to_i32_sp_arbiter.sv
// fp_to_i32_sp_arbiter
//
// Shares one single-precision float-to-int32 converter among NUM_REQ requesters.
// A round-robin arbiter picks at most one requester per clock-enabled cycle, the
// granted 34-bit FloPoCo operand goes through the converter (NUM_STAGES of latency),
// and a tag pipeline of matching depth routes each result back to its owner.
//
// Conversion: round toward zero. Finite out-of-range values, +/-inf and NaN
// saturate. NaN returns 32'h8000_0000.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, overrides ce
//   ce         clock enable; low freezes every register
//   req_valid  per-requester request valid
//   req_data   per-requester operand, requester i at [34*i+33:34*i]
//   req_ready  one-hot grant (zero when idle, in reset or frozen)
//   rsp_valid  one-hot result strobe for the owner of rsp_data
//   rsp_data   int32 result, held between responses
//   inflight   accepted conversions not yet presented on rsp_*
module fp_to_i32_sp_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_STAGES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ce,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*34-1:0]             req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [31:0]                       rsp_data,
    output logic [$clog2(NUM_STAGES+2)-1:0]   inflight
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned InfW = $clog2(NUM_STAGES + 2);

    if (NUM_STAGES != 0 && NUM_STAGES != 1 && NUM_STAGES != 6) begin : g_bad_stages
        $error("NUM_STAGES must be 0, 1 or 6");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_req
        $error("NUM_REQ must be in 2..16");
    end

    // FloPoCo exception field: 00 zero, 01 normal, 10 infinity, 11 NaN.
    function automatic logic [31:0] fp_to_i32(input logic [33:0] op);
        logic [1:0]  exc;
        logic        sgn;
        logic [7:0]  ex;
        logic [31:0] man;
        logic [31:0] mag;
        logic [31:0] res;
        exc = op[33:32];
        sgn = op[31];
        ex  = op[30:23];
        man = {8'h00, 1'b1, op[22:0]};
        mag = '0;
        res = '0;
        case (exc)
            2'b00: res = '0;
            2'b01: begin
                if (ex < 8'd127) begin
                    res = '0;
                end else if (ex >= 8'd158) begin
                    // |x| >= 2^31: only -2^31 is exact, and it equals the saturation value
                    res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end else begin
                    // value = man * 2^(ex-150)
                    if (ex >= 8'd150) begin
                        mag = man << (ex - 8'd150);
                    end else begin
                        mag = man >> (8'd150 - ex);
                    end
                    res = sgn ? (~mag + 32'd1) : mag;
                end
            end
            2'b10:   res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: res = 32'h8000_0000;
        endcase
        return res;
    endfunction

    // ---------------------------------------------------------------- arbitration
    logic [IdW-1:0]     rr_ptr_q;
    logic [IdW-1:0]     rr_ptr_d;
    logic [IdW-1:0]     grant_id;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;
    logic               transfer;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        grant     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[IdW'(idx)]) begin
                grant_any = 1'b1;
                grant_id  = IdW'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant & {NUM_REQ{ce & ~rst}};
    assign transfer  = grant_any & ce & ~rst;

    always_comb begin
        if (grant_id == IdW'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_id + IdW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (transfer) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ---------------------------------------------------------------- converter
    logic [33:0] conv_in;
    logic [31:0] conv_comb;
    logic [31:0] conv_out;
    logic        enter_v;   // a valid tag moves into the output stage this edge

    // Idle cycles feed zeros so the converter does not toggle on stale data.
    always_comb begin
        conv_in = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_any && grant_id == IdW'(i)) begin
                conv_in = req_data[34*i +: 34];
            end
        end
    end

    assign conv_comb = fp_to_i32(conv_in);

    // ---------------------------------------------------------------- tag pipeline
    logic [NUM_STAGES:0] tag_v_q;
    logic [IdW-1:0]      tag_id_q [NUM_STAGES+1];

    if (NUM_STAGES == 0) begin : g_comb
        assign conv_out = conv_comb;
        assign enter_v  = transfer;
    end else begin : g_pipe
        logic [31:0] pipe_q [NUM_STAGES];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(NUM_STAGES); i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (ce) begin
                pipe_q[0] <= conv_comb;
                for (int i = 1; i < int'(NUM_STAGES); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign conv_out = pipe_q[NUM_STAGES-1];
        assign enter_v  = tag_v_q[NUM_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
            for (int i = 0; i <= int'(NUM_STAGES); i++) begin
                tag_id_q[i] <= '0;
            end
        end else if (ce) begin
            tag_v_q[0]  <= transfer;
            tag_id_q[0] <= grant_id;
            for (int i = 1; i <= int'(NUM_STAGES); i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // ---------------------------------------------------------------- response
    logic [31:0] rsp_data_q;

    // Load only alongside a valid tag so rsp_data holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= '0;
        end else if (ce && enter_v) begin
            rsp_data_q <= conv_out;
        end
    end

    assign rsp_data = rsp_data_q;

    always_comb begin
        rsp_valid = '0;
        if (tag_v_q[NUM_STAGES]) begin
            rsp_valid[tag_id_q[NUM_STAGES]] = 1'b1;
        end
    end

    // The output stage is excluded: its result is already being presented.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            inflight = inflight + InfW'(tag_v_q[i]);
        end
    end

endmodule

// File: tb/tb_fp_to_i32_sp_arbiter.sv
// Bench for fp_to_i32_sp_arbiter: three instances (NUM_STAGES 0, 1, 6) share the
// same stimulus. A scoreboard queue holds every accepted request with its
// clock-enabled acceptance count; each instance presents entry n when the
// count reaches acc + latency.
module tb_fp_to_i32_sp_arbiter;

    localparam int NR = 4;
    localparam int NV = 16;

    typedef struct {
        logic [33:0] op;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        int          acc;
        int          id;
        logic [31:0] data;
    } ent_t;

    vec_t tab [NV];
    ent_t sb [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce  = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [135:0]  req_data  = '0;

    logic [3:0]  rdy0, rdy1, rdy6, rv0, rv1, rv6;
    logic [31:0] rd0, rd1, rd6;
    logic [0:0]  inf0;
    logic [1:0]  inf1;
    logic [2:0]  inf6;

    logic [3:0]  rdy_a [3];
    logic [3:0]  rv_a  [3];
    logic [31:0] rd_a  [3];
    logic [2:0]  inf_a [3];

    int          lat [3] = '{0, 1, 6};
    int          hd  [3] = '{0, 0, 0};
    logic [31:0] last [3] = '{32'h0, 32'h0, 32'h0};
    int          ccount = 0;
    int          ptr = 0;
    int          vi [4];
    logic [3:0]  want = '0;
    logic [3:0]  acc_flag = '0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          peak = 0;

    always #5 clk = ~clk;

    fp_to_i32_sp_arbiter #(.NUM_REQ(4), .NUM_STAGES(0)) u_s0 (
        .clk(clk), .rst(rst), .ce(ce), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .rsp_valid(rv0), .rsp_data(rd0), .inflight(inf0)
    );
    fp_to_i32_sp_arbiter #(.NUM_REQ(4), .NUM_STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .ce(ce), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .rsp_valid(rv1), .rsp_data(rd1), .inflight(inf1)
    );
    fp_to_i32_sp_arbiter #(.NUM_REQ(4), .NUM_STAGES(6)) u_s6 (
        .clk(clk), .rst(rst), .ce(ce), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy6), .rsp_valid(rv6), .rsp_data(rd6), .inflight(inf6)
    );

    assign rdy_a[0] = rdy0;
    assign rdy_a[1] = rdy1;
    assign rdy_a[2] = rdy6;
    assign rv_a[0]  = rv0;
    assign rv_a[1]  = rv1;
    assign rv_a[2]  = rv6;
    assign rd_a[0]  = rd0;
    assign rd_a[1]  = rd1;
    assign rd_a[2]  = rd6;
    assign inf_a[0] = {2'b00, inf0};
    assign inf_a[1] = {1'b0, inf1};
    assign inf_a[2] = inf6;

    function automatic logic [3:0] exp_grant(input logic [3:0] v, input int p);
        int k;
        for (int o = 0; o < NR; o++) begin
            k = (p + o) % NR;
            if (v[k]) return 4'b0001 << k;
        end
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input int s, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, s, $time, act, exp);
        end
    endtask

    // Reference model: grant order, acceptance record, presentation bookkeeping.
    always @(posedge clk) begin
        logic [3:0] g;
        ent_t       e;
        acc_flag = 4'b0000;
        if (rst) begin
            ptr    = 0;
            chk_en = 1'b1;
            for (int s = 0; s < 3; s++) begin
                hd[s]   = sb.size();
                last[s] = 32'h0;
            end
        end else if (ce) begin
            for (int s = 0; s < 3; s++) begin
                if (hd[s] < sb.size()) begin
                    if (sb[hd[s]].acc + lat[s] == ccount) begin
                        last[s] = sb[hd[s]].data;
                        hd[s]++;
                    end
                end
            end
            g = exp_grant(req_valid, ptr);
            for (int k = 0; k < NR; k++) begin
                if (g[k]) begin
                    e.acc  = ccount + 1;
                    e.id   = k;
                    e.data = tab[vi[k]].res;
                    sb.push_back(e);
                    ptr = (k + 1) % NR;
                    acc_flag[k] = 1'b1;
                end
            end
            ccount++;
        end
    end

    always @(negedge clk) begin
        logic [3:0]  eg;
        logic [3:0]  ev;
        logic [31:0] ed;
        int          pres;
        if (chk_en) begin
            eg = (ce && !rst) ? exp_grant(req_valid, ptr) : 4'b0000;
            for (int s = 0; s < 3; s++) begin
                pres = 0;
                ev   = 4'b0000;
                ed   = last[s];
                if (hd[s] < sb.size()) begin
                    if (sb[hd[s]].acc + lat[s] == ccount) begin
                        pres = 1;
                        ev   = 4'b0001 << sb[hd[s]].id;
                        ed   = sb[hd[s]].data;
                    end
                end
                chk("req_ready", s, 32'(rdy_a[s]), 32'(eg));
                chk("rsp_valid", s, 32'(rv_a[s]), 32'(ev));
                chk("rsp_data", s, rd_a[s], ed);
                chk("inflight", s, 32'(inf_a[s]), 32'(sb.size() - hd[s] - pres));
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = want[i];
            req_data[34*i +: 34] = tab[vi[i]].op;
        end
    endtask

    // Requesters advance to their next vector once accepted.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_flag[i]) vi[i] = (vi[i] + 1) % NV;
        end
        drive();
    endtask

    initial begin
        tab[0]  = '{34'h1_3F80_0000, 32'h0000_0001};  //  1.0
        tab[1]  = '{34'h1_4040_0000, 32'h0000_0003};  //  3.0
        tab[2]  = '{34'h1_C0E0_0000, 32'hFFFF_FFF9};  // -7.0
        tab[3]  = '{34'h0_0000_0000, 32'h0000_0000};  //  zero
        tab[4]  = '{34'h1_3F00_0000, 32'h0000_0000};  //  0.5
        tab[5]  = '{34'h1_4030_0000, 32'h0000_0002};  //  2.75
        tab[6]  = '{34'h1_C030_0000, 32'hFFFF_FFFE};  // -2.75
        tab[7]  = '{34'h1_4F00_0000, 32'h7FFF_FFFF};  //  2^31
        tab[8]  = '{34'h1_CF00_0000, 32'h8000_0000};  // -2^31
        tab[9]  = '{34'h2_0000_0000, 32'h7FFF_FFFF};  // +inf
        tab[10] = '{34'h2_8000_0000, 32'h8000_0000};  // -inf
        tab[11] = '{34'h3_0000_0000, 32'h8000_0000};  //  NaN
        tab[12] = '{34'h1_4780_0000, 32'h0001_0000};  //  65536.0
        tab[13] = '{34'h1_4EC0_0000, 32'h6000_0000};  //  1.5 * 2^30
        tab[14] = '{34'h1_42F6_0000, 32'h0000_007B};  //  123.0
        tab[15] = '{34'h1_BF80_0000, 32'hFFFF_FFFF};  // -1.0
        for (int i = 0; i < NR; i++) vi[i] = i;
        drive();

        repeat (3) next_cycle();
        rst = 1'b0;
        drive();
        repeat (2) next_cycle();

        // Single request from requester 2 with 1.0
        vi[2] = 0;
        want  = 4'b0100;
        drive();
        @(negedge clk);
        chk("single_grant", 1, 32'(rdy1), 32'h4);
        next_cycle();
        want = 4'b0000;
        drive();
        @(negedge clk);
        chk("single_inflight", 1, 32'(inf1), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("single_rsp_valid", 1, 32'(rv1), 32'h4);
        chk("single_rsp_data", 1, rd1, 32'h1);
        repeat (5) next_cycle();

        // Full contention after reset: order 0,1,2,3,0,1,2,3
        rst = 1'b1;
        drive();
        next_cycle();
        rst   = 1'b0;
        vi[0] = 1;
        vi[1] = 2;
        vi[2] = 14;
        vi[3] = 12;
        want  = 4'b1111;
        drive();
        peak = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_order", 2, 32'(rdy6), 32'(4'b0001 << (c % 4)));
            if (int'(inf6) > peak) peak = int'(inf6);
            next_cycle();
        end
        want = 4'b0000;
        drive();
        repeat (10) begin
            @(negedge clk);
            if (int'(inf6) > peak) peak = int'(inf6);
            next_cycle();
        end
        chk("peak_inflight", 2, 32'(peak), 32'd6);

        // Round-robin resume: last grant to 1, then 0 and 3 together
        want = 4'b0010;
        drive();
        next_cycle();
        want = 4'b1001;
        drive();
        @(negedge clk);
        chk("rr_resume_first", 2, 32'(rdy6), 32'h8);
        next_cycle();
        @(negedge clk);
        chk("rr_resume_second", 2, 32'(rdy6), 32'h1);
        next_cycle();
        want = 4'b0000;
        drive();
        repeat (10) next_cycle();

        // Freeze two cycles after a grant, for 4 cycles
        vi[0] = 2;
        want  = 4'b0001;
        drive();
        next_cycle();
        want = 4'b0000;
        drive();
        next_cycle();
        ce   = 1'b0;
        want = 4'b1111;
        drive();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("freeze_no_grant", 2, 32'(rdy6), 32'h0);
            chk("freeze_inflight", 2, 32'(inf6), 32'd1);
            next_cycle();
        end
        ce   = 1'b1;
        want = 4'b0000;
        drive();
        repeat (5) next_cycle();
        @(negedge clk);
        chk("freeze_rsp_valid", 2, 32'(rv6), 32'h1);
        chk("freeze_rsp_data", 2, rd6, 32'hFFFF_FFF9);
        repeat (3) next_cycle();

        // Reset with three conversions in flight
        want = 4'b1111;
        drive();
        repeat (3) next_cycle();
        rst = 1'b1;
        drive();
        @(negedge clk);
        chk("rst_no_grant", 2, 32'(rdy6), 32'h0);
        next_cycle();
        rst  = 1'b0;
        want = 4'b0000;
        drive();
        @(negedge clk);
        chk("rst_inflight", 2, 32'(inf6), 32'd0);
        chk("rst_rsp_valid", 2, 32'(rv6), 32'h0);
        chk("rst_rsp_data", 2, rd6, 32'h0);
        repeat (10) next_cycle();
        want = 4'b1111;
        drive();
        @(negedge clk);
        chk("rst_ptr", 2, 32'(rdy6), 32'h1);
        next_cycle();
        want = 4'b0000;
        drive();
        repeat (10) next_cycle();

        // Conversion table, one vector per cycle on rotating requesters
        for (int j = 0; j < NV; j++) begin
            vi[j % NR] = j;
            want = 4'b0001 << (j % NR);
            drive();
            next_cycle();
            @(negedge clk);
            chk("vec_data", 0, rd0, tab[j].res);
        end
        want = 4'b0000;
        drive();
        repeat (10) next_cycle();

        // Zero latency: back-to-back stream from requester 1
        want = 4'b0010;
        drive();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c > 0) chk("zl_rsp_valid", 0, 32'(rv0), 32'h2);
            next_cycle();
        end
        want = 4'b0000;
        drive();
        repeat (3) next_cycle();

        // Random mix of requests, freezes and resets
        for (int c = 0; c < 300; c++) begin
            want = 4'($urandom_range(0, 15));
            ce   = ($urandom_range(0, 7) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            drive();
            next_cycle();
        end
        rst  = 1'b0;
        ce   = 1'b1;
        want = 4'b0000;
        drive();
        repeat (12) next_cycle();

        for (int s = 0; s < 3; s++) begin
            chk("drained", s, 32'(hd[s]), 32'(sb.size()));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
